// File: rtl/nx_ram_hw_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : nx_ram_hw_seq_if
// Brief    : Bundle of the request/response stream and the RAM-wrapper
//            hw_* port driven by nx_ram_hw_seq.
//            slave  - the sequencer's view (serves requests, drives hw_*)
//            master - the surrounding logic's view (issues requests, models
//                     the wrapper)
// Revision : 1.0 - initial release
// ============================================================================
interface nx_ram_hw_seq_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 38
);
    // Request stream
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_bwe;
    logic [DATA_W-1:0] req_wdat;
    // Response stream
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_dat;
    logic              init_done;
    // RAM wrapper hardware port
    logic [ADDR_W-1:0] hw_add;
    logic              hw_we;
    logic [DATA_W-1:0] hw_bwe;
    logic              hw_cs;
    logic [DATA_W-1:0] hw_din;
    logic [DATA_W-1:0] hw_dout;
    logic              hw_yield;

    modport slave (
        input  req_valid, req_we, req_addr, req_bwe, req_wdat, rsp_ready,
               hw_dout, hw_yield,
        output req_ready, rsp_valid, rsp_dat, init_done,
               hw_add, hw_we, hw_bwe, hw_cs, hw_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_bwe, req_wdat, rsp_ready,
               hw_dout, hw_yield,
        input  req_ready, rsp_valid, rsp_dat, init_done,
               hw_add, hw_we, hw_bwe, hw_cs, hw_din
    );
endinterface
`default_nettype wire

// File: rtl/nx_ram_hw_seq.sv
`default_nettype none
// ============================================================================
// Module   : nx_ram_hw_seq
// Brief    : Hardware-side request sequencer for a 1RW indirect-access RAM
//            wrapper. Fills the RAM after reset, then forwards a valid/ready
//            request stream; read data returns in order through a
//            credit-protected response FIFO. Backs off on hw_yield.
// Options  : NX_RAM_HW_SEQ_SKIP_INIT_EN - come out of reset in RUN with no
//            init sweep (init_done rises one cycle after reset release).
// Revision : 1.0 - initial release
// ============================================================================
module nx_ram_hw_seq #(
    parameter int                     N_ENTRIES   = 16384,
    parameter int                     N_DATA_BITS = 38,
    parameter int                     RD_LATENCY  = 1,
    parameter int                     RSP_DEPTH   = 4,
    parameter logic [N_DATA_BITS-1:0] INIT_DATA   = '0
) (
    input wire             clk,
    input wire             rst,
    nx_ram_hw_seq_if.slave bus
);

    localparam int c_ADDR_W = $clog2(N_ENTRIES);
    localparam int c_PTR_W  = $clog2(RSP_DEPTH) + 1;
    localparam int c_CRD_W  = $clog2(RSP_DEPTH + 1);
    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(N_ENTRIES - 1);
    localparam logic [c_CRD_W-1:0]  c_CRD_MAX   = c_CRD_W'(RSP_DEPTH);

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;
`ifdef NX_RAM_HW_SEQ_SKIP_INIT_EN
    localparam logic [0:0] c_ST_RESET = c_ST_RUN;
`else
    localparam logic [0:0] c_ST_RESET = c_ST_INIT;
`endif

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [c_ADDR_W-1:0]    r_init_cnt;
    logic                   r_init_done;
    logic [c_CRD_W-1:0]     r_credits;
    logic [RD_LATENCY-1:0]  r_rd_vld;
    logic [N_DATA_BITS-1:0] r_fifo [RSP_DEPTH];
    logic [c_PTR_W-1:0]     r_wptr;
    logic [c_PTR_W-1:0]     r_rptr;

    logic                   w_hw_cs;
    logic                   w_hw_we;
    logic [c_ADDR_W-1:0]    w_hw_add;
    logic [N_DATA_BITS-1:0] w_hw_bwe;
    logic [N_DATA_BITS-1:0] w_hw_din;
    logic                   w_req_ready;
    logic                   w_init_last_wr;
    logic                   w_rd_issue;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_full;

    // Response FIFO status; full/empty come from the pointer wrap bit.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_PTR_W-1] != r_rptr[c_PTR_W-1]) &&
                     (r_wptr[c_PTR_W-2:0] == r_rptr[c_PTR_W-2:0]);
    assign w_pop   = !w_empty && bus.rsp_ready;
    assign w_push  = r_rd_vld[RD_LATENCY-1];

    assign w_init_last_wr = (r_state == c_ST_INIT) && w_hw_cs && (r_init_cnt == c_LAST_ADDR);
    assign w_rd_issue     = w_hw_cs && !w_hw_we && (r_state == c_ST_RUN);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_RESET;
        else     r_state <= w_state_nxt;
    end

    // Next state: leave INIT once the last entry has been written.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_ST_INIT && w_init_last_wr) w_state_nxt = c_ST_RUN;
    end

    // Outputs: init writes in INIT, pass-through of accepted requests in RUN.
    // A read may be accepted in the same cycle as a pop frees a credit.
    always_comb begin
        w_hw_cs     = 1'b0;
        w_hw_we     = 1'b0;
        w_hw_add    = '0;
        w_hw_bwe    = '0;
        w_hw_din    = '0;
        w_req_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                c_ST_INIT: begin
                    if (!bus.hw_yield) begin
                        w_hw_cs  = 1'b1;
                        w_hw_we  = 1'b1;
                        w_hw_add = r_init_cnt;
                        w_hw_bwe = '1;
                        w_hw_din = INIT_DATA;
                    end
                end
                c_ST_RUN: begin
                    w_req_ready = r_init_done && !bus.hw_yield &&
                                  (bus.req_we || (r_credits != '0) || w_pop);
                    if (bus.req_valid && w_req_ready) begin
                        w_hw_cs  = 1'b1;
                        w_hw_we  = bus.req_we;
                        w_hw_add = bus.req_addr;
                        w_hw_bwe = bus.req_bwe;
                        w_hw_din = bus.req_wdat;
                    end
                end
                default: ;
            endcase
        end
    end

    // Init address counter and init_done flag; the counter saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state == c_ST_INIT && w_hw_cs && r_init_cnt != c_LAST_ADDR)
                r_init_cnt <= r_init_cnt + c_ADDR_W'(1);
            if (r_state == c_ST_RUN || w_init_last_wr)
                r_init_done <= 1'b1;
        end
    end

    // Credits: one per free FIFO slot not already claimed by a read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       r_credits <= c_CRD_MAX;
        else if (w_rd_issue && !w_pop) r_credits <= r_credits - c_CRD_W'(1);
        else if (!w_rd_issue && w_pop) r_credits <= r_credits + c_CRD_W'(1);
    end

    // Read-valid delay line matching the wrapper read latency.
    generate
        if (RD_LATENCY == 1) begin : g_lat_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_rd_vld <= '0;
                else     r_rd_vld <= w_rd_issue;
            end
        end else begin : g_lat_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_rd_vld <= '0;
                else     r_rd_vld <= {r_rd_vld[RD_LATENCY-2:0], w_rd_issue};
            end
        end
    endgenerate

    // FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
        end
    end

    // FIFO storage; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr[c_PTR_W-2:0]] <= bus.hw_dout;
    end

    assign bus.hw_cs     = w_hw_cs;
    assign bus.hw_we     = w_hw_we;
    assign bus.hw_add    = w_hw_add;
    assign bus.hw_bwe    = w_hw_bwe;
    assign bus.hw_din    = w_hw_din;
    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = !w_empty;
    assign bus.rsp_dat   = r_fifo[r_rptr[c_PTR_W-2:0]];
    assign bus.init_done = r_init_done;

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full && !w_pop));
    a_credit_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(w_rd_issue && !w_pop && r_credits == '0));
    a_credit_no_overflow: assert property (@(posedge clk) disable iff (rst)
        r_credits <= c_CRD_MAX);

endmodule
`default_nettype wire
